i2s_tx_serializer: RTL and testbench

I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

---
 rtl/i2s_tx_serializer_pkg.sv | 12 +
 rtl/i2s_bclk_gen.sv | 47 ++++
 rtl/i2s_tx_serializer.sv | 135 +++++++++++++
 tb/tb_i2s_tx_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_serializer_pkg.sv
// rtl/i2s_tx_serializer_pkg.sv - shared audio types and slot-width constant for the I2S transmitter
package i2s_tx_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_e;

    localparam int I2S_SLOT_BITS = 16;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - BCLK divider producing the bit clock and a fall-event strobe
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic fall_evt
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          term;

    assign term     = (cnt_q == TERM);
    assign fall_evt = run && term && bclk_q;
    assign bclk     = bclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (!run) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - mono-duplicated I2S transmitter with one-entry sample holding register
module i2s_tx_serializer
    import i2s_tx_serializer_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = I2S_SLOT_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [WORD_BITS-1:0] sample_in,
    input  logic                        sample_valid,
    input  logic                        clear_flags,
    output logic                        bclk,
    output logic                        lrclk,
    output logic                        sdata,
    output logic                        frame_req,
    output logic                        underflow,
    output logic                        overflow
);

    localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

    i2s_state_e          state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d, next_bit;
    logic                 started_q, started_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 frame_req_q, frame_req_d;
    logic [WORD_BITS-1:0] frame_word_q, frame_word_d;
    logic [WORD_BITS-1:0] hold_q, hold_d;
    logic                 valid_q, valid_d;
    logic                 underflow_q, underflow_d;
    logic                 overflow_q, overflow_d;
    logic [WORD_BITS-1:0] word_sel;
    logic                 load, run, fall_evt;

    assign run = (state_q != ST_IDLE) && enable;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    // An empty holding register at frame start repeats the previous word
    assign word_sel = valid_q ? hold_q : frame_word_q;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        started_d   = started_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        frame_req_d = 1'b0;
        load        = 1'b0;
        next_bit    = bit_q;
        if (!enable) begin
            state_d   = ST_IDLE;
            bit_d     = '0;
            started_d = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_LEFT;
        end else if (fall_evt) begin
            if (!started_q) begin
                started_d = 1'b1;
                next_bit  = '0;
                load      = 1'b1;
            end else if (bit_q == LAST_BIT) begin
                next_bit = '0;
                if (state_q == ST_LEFT) begin
                    state_d = ST_RIGHT;
                end else begin
                    state_d = ST_LEFT;
                    load    = 1'b1;
                end
            end else begin
                next_bit = bit_q + 1'b1;
            end
            bit_d = next_bit;
            // Word select leads the slot by one bit
            if (next_bit == LAST_BIT) begin
                lrclk_d = ~lrclk_q;
            end
            frame_req_d = load;
            sdata_d     = load ? word_sel[LAST_BIT - next_bit] : frame_word_q[LAST_BIT - next_bit];
        end

        frame_word_d = load ? word_sel : frame_word_q;
        hold_d       = sample_valid ? sample_in : hold_q;
        valid_d      = sample_valid ? 1'b1 : (load ? 1'b0 : valid_q);
        underflow_d  = (underflow_q & ~clear_flags) | (load && !valid_q && !sample_valid);
        overflow_d   = (overflow_q & ~clear_flags) | (sample_valid && valid_q && !load);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_q        <= '0;
            started_q    <= 1'b0;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            frame_req_q  <= 1'b0;
            frame_word_q <= '0;
            hold_q       <= '0;
            valid_q      <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            started_q    <= started_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            frame_req_q  <= frame_req_d;
            frame_word_q <= frame_word_d;
            hold_q       <= hold_d;
            valid_q      <= valid_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
        end
    end

    assign lrclk     = lrclk_q;
    assign sdata     = sdata_q;
    assign frame_req = frame_req_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - self-checking bench for i2s_tx_serializer
module tb_i2s_tx_serializer;

    localparam int D = 2;
    localparam int W = 16;
    localparam int FRAME = 4 * D * W;

    logic clk = 1'b0;
    logic reset, enable, sample_valid, clear_flags;
    logic signed [W-1:0] sample_in;
    logic bclk, lrclk, sdata, frame_req, underflow, overflow;

    i2s_tx_serializer #(.CLK_DIV(D), .WORD_BITS(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear_flags  (clear_flags),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_req    (frame_req),
        .underflow    (underflow),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic s_reset, s_en, s_sv, s_clr;
    logic [W-1:0] s_si;

    bit armed = 0;
    bit m_run = 0;
    int k = 0;
    logic [W-1:0] m_hold = '0, m_fw = '0;
    bit m_valid = 0, m_unf = 0, m_ovf = 0;

    logic [W-1:0] rx = '0;
    logic prev_lr = 1'b0, prev_bclk = 1'b0;
    logic [W-1:0] rx_words[$];
    bit rx_slot[$];
    int fr_times[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        s_reset = reset; s_en = enable; s_sv = sample_valid; s_clr = clear_flags; s_si = sample_in;
        cyc++;
    end

    // Reference model: outputs follow from elapsed edges since enable and the frame arithmetic
    initial forever begin
        bit load, set_u, set_o;
        int g;
        logic e_bclk, e_lr, e_sd;
        @(negedge clk);
        if (s_reset) begin
            armed = 1; m_run = 0; k = 0;
            m_hold = '0; m_fw = '0; m_valid = 0; m_unf = 0; m_ovf = 0;
            load = 0;
        end else begin
            load = 0;
            if (!s_en) begin m_run = 0; k = 0; end
            else if (!m_run) begin m_run = 1; k = 0; end
            else begin
                k++;
                load = (k >= 2 * D) && (((k - 2 * D) % FRAME) == 0);
            end
            set_u = load && !m_valid && !s_sv;
            set_o = s_sv && m_valid && !load;
            if (load && m_valid) m_fw = m_hold;
            if (s_sv) begin m_hold = s_si; m_valid = 1; end
            else if (load) m_valid = 0;
            m_unf = (m_unf && !s_clr) || set_u;
            m_ovf = (m_ovf && !s_clr) || set_o;
        end
        e_bclk = m_run ? 1'((k / D) % 2) : 1'b0;
        e_lr = 1'b0; e_sd = 1'b0;
        if (m_run && k >= 2 * D) begin
            g = k / (2 * D) - 1;
            e_sd = m_fw[W - 1 - (g % W)];
            e_lr = 1'(((g + 1) / W) % 2);
        end
        if (armed) begin
            chk("bclk", bclk, e_bclk);
            chk("lrclk", lrclk, e_lr);
            chk("sdata", sdata, e_sd);
            chk("frame_req", frame_req, load);
            chk("underflow", underflow, m_unf);
            chk("overflow", overflow, m_ovf);
        end
        if (frame_req) fr_times.push_back(cyc);
        if (s_reset || !s_en) begin
            prev_lr = 1'b0; prev_bclk = 1'b0;
        end else begin
            if (bclk && !prev_bclk) begin
                rx = {rx[W-2:0], sdata};
                if (lrclk != prev_lr) begin
                    rx_words.push_back(rx);
                    rx_slot.push_back(prev_lr);
                end
                prev_lr = lrclk;
            end
            prev_bclk = bclk;
        end
    end

    task automatic pulse_sample(input logic [W-1:0] v);
        sample_in = v; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
    endtask

    task automatic at_edge(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic wait_frame(output int base, output int frc);
        int n = fr_times.size();
        int i = 0;
        while (fr_times.size() == n && i < 2 * FRAME) begin @(negedge clk); #1; i++; end
        if (fr_times.size() == n) begin
            checks++; errors++;
            $display("FAIL frame_req_timeout: got none expected pulse within %0d clk", 2 * FRAME);
            frc = cyc;
        end else frc = fr_times[$];
        base = rx_words.size();
    endtask

    task automatic check_frame(input string name, input int base, input logic [W-1:0] v);
        int i = 0;
        while (rx_words.size() < base + 2 && i < 2 * FRAME) begin @(negedge clk); #1; i++; end
        if (rx_words.size() < base + 2) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, rx_words.size(), base + 2);
        end else begin
            chk({name, "_left"}, rx_words[base], v);
            chk({name, "_left_slot"}, rx_slot[base], 0);
            chk({name, "_right"}, rx_words[base + 1], v);
            chk({name, "_right_slot"}, rx_slot[base + 1], 1);
        end
    endtask

    initial begin
        int b0, f0, b1, f1, b2, f2, b3, f3, b4, f4, b5, f5, b6, f6, b7, f7, b8, f8;
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; clear_flags = 1'b0; sample_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_bclk", bclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_flags", {underflow, overflow}, 0);

        pulse_sample(16'h8001);
        enable = 1'b1;
        wait_frame(b0, f0);
        chk("first_frame_no_underflow", underflow, 0);
        wait_frame(b1, f1);
        chk("frame_req_period", f1 - f0, FRAME);
        chk("underflow_after_miss", underflow, 1);
        check_frame("f0_8001", b0, 16'h8001);
        check_frame("f1_repeat", b1, 16'h8001);
        wait_frame(b2, f2);
        check_frame("f2_repeat", b2, 16'h8001);
        wait_frame(b3, f3);
        repeat (8) @(posedge clk);
        #1 pulse_clear();
        chk("underflow_cleared", underflow, 0);

        pulse_sample(16'h1234);
        repeat (3) @(posedge clk);
        #1 pulse_sample(16'h5678);
        chk("overflow_set", overflow, 1);
        wait_frame(b4, f4);
        chk("no_underflow_with_sample", underflow, 0);
        pulse_sample(16'hAAAA);
        pulse_clear();
        chk("overflow_cleared", overflow, 0);
        at_edge(f4 + FRAME - 1);
        pulse_sample(16'h00FF);
        check_frame("f4_5678", b4, 16'h5678);
        wait_frame(b5, f5);
        chk("coincident_edge", f5 - f4, FRAME);
        check_frame("f5_old_word", b5, 16'hAAAA);
        wait_frame(b6, f6);
        check_frame("f6_00ff", b6, 16'h00FF);
        chk("coincident_no_flags", {underflow, overflow}, 0);

        wait_frame(b7, f7);
        at_edge(f7 + 4 * (W - 1) - 1);
        chk("lrclk_before_bit15", lrclk, 0);
        at_edge(f7 + 4 * (W - 1));
        chk("lrclk_at_bit15", lrclk, 1);
        at_edge(f7 + 95);
        chk("lrclk_mid_right", lrclk, 1);
        reset = 1'b1; enable = 1'b0;
        at_edge(f7 + 96);
        chk("midreset_outputs", {bclk, lrclk, sdata, frame_req}, 0);
        chk("midreset_flags", {underflow, overflow}, 0);
        reset = 1'b0;
        pulse_sample(16'h0F0F);
        enable = 1'b1;
        wait_frame(b8, f8);
        check_frame("restart_0f0f", b8, 16'h0F0F);
        chk("restart_no_underflow", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
